// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_pkg
//  Description : Shared types and constants for the Pac-Man movement
//                controller: direction encoding, FSM state encoding, tile
//                size and default playfield bounds, plus a helper that
//                returns the opposite of a direction.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package pacman_pkg;

    // Direction encoding; NONE means "not moving".
    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    // Movement FSM states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TURN_Q = 2'd1,
        S_FWD_Q  = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    localparam int c_TILE_SHIFT = 3;
    localparam int c_X_MAX      = 272;
    localparam int c_Y_MAX      = 208;

    // Opposite direction; NONE maps to NONE.
    function automatic dir_t f_opposite(input dir_t d);
        dir_t r;
        case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            RIGHT:   r = LEFT;
            default: r = NONE;
        endcase
        return r;
    endfunction

endpackage : pacman_pkg
`default_nettype wire

// File: rtl/pacman_next_tile.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_next_tile
//  Description : Combinational neighbour-tile calculator. Converts a pixel
//                position to tile coordinates, offsets them one tile in the
//                given direction and flags tiles that fall off the grid.
//  Ports       : i_x, i_y        pixel position (10 bit)
//                i_dir           direction to look in (NONE = current tile)
//                o_row, o_col    neighbour tile (row on x axis, col on y axis)
//                o_out_of_grid   neighbour lies outside the maze
//  Revision    : 1.0  initial release
// ============================================================================
module pacman_next_tile
    import pacman_pkg::*;
#(
    parameter int X_MAX      = c_X_MAX,
    parameter int Y_MAX      = c_Y_MAX,
    parameter int TILE_SHIFT = c_TILE_SHIFT
) (
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  dir_t       i_dir,
    output logic [6:0] o_row,
    output logic [6:0] o_col,
    output logic       o_out_of_grid
);

    localparam logic signed [7:0] c_ROW_MAX = 8'(X_MAX >> TILE_SHIFT);
    localparam logic signed [7:0] c_COL_MAX = 8'(Y_MAX >> TILE_SHIFT);

    // Tile indices are at most 127 for a 10-bit position with 8-pixel
    // tiles, so they sit in the positive half of a signed byte and a
    // step to -1 stays representable instead of wrapping.
    logic signed [7:0] w_row_cur;
    logic signed [7:0] w_col_cur;
    logic signed [7:0] w_dr;
    logic signed [7:0] w_dc;
    logic signed [7:0] w_row_n;
    logic signed [7:0] w_col_n;

    assign w_row_cur = 8'(i_x >> TILE_SHIFT);
    assign w_col_cur = 8'(i_y >> TILE_SHIFT);

    always_comb begin
        w_dr = 8'sd0;
        w_dc = 8'sd0;
        case (i_dir)
            UP:      w_dr = -8'sd1;
            DOWN:    w_dr =  8'sd1;
            LEFT:    w_dc = -8'sd1;
            RIGHT:   w_dc =  8'sd1;
            default: ;
        endcase
    end

    assign w_row_n = w_row_cur + w_dr;
    assign w_col_n = w_col_cur + w_dc;

    assign o_row         = w_row_n[6:0];
    assign o_col         = w_col_n[6:0];
    assign o_out_of_grid = (w_row_n < 8'sd0) || (w_row_n > c_ROW_MAX) ||
                           (w_col_n < 8'sd0) || (w_col_n > c_COL_MAX);

endmodule : pacman_next_tile
`default_nettype wire

// File: rtl/pacman_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_move_ctrl
//  Description : Pac-Man movement controller. Latches the joystick into a
//                desired direction, and on each movement tick either
//                reverses, queries the maze for a turn / forward move at
//                tile-aligned positions, or steps one pixel mid-tile.
//  Ports       : i_clk, i_rst                 clock, sync active-high reset
//                i_up/i_down/i_left/i_right   level joystick inputs
//                i_tick                       movement strobe (IDLE only)
//                o_query_req/row/col          maze tile query
//                i_query_ack/i_query_wall     query response
//                w_pacman_x/w_pacman_y        pixel position
//                o_dir                        current direction (dir_t)
//                o_busy                       FSM not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int X_MAX      = c_X_MAX,
    parameter int Y_MAX      = c_Y_MAX,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int TILE_SHIFT = c_TILE_SHIFT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_tick,
    output logic       o_query_req,
    output logic [6:0] o_query_row,
    output logic [6:0] o_query_col,
    input  logic       i_query_ack,
    input  logic       i_query_wall,
    output logic [9:0] w_pacman_x,
    output logic [9:0] w_pacman_y,
    output logic [2:0] o_dir,
    output logic       o_busy
);

    localparam logic [9:0] c_XMAX_L  = 10'(X_MAX);
    localparam logic [9:0] c_YMAX_L  = 10'(Y_MAX);
    localparam logic [9:0] c_START_X = 10'(START_X);
    localparam logic [9:0] c_START_Y = 10'(START_Y);

    state_t     r_state_q,   w_state_d;
    dir_t       r_dir_q,     w_dir_d;
    dir_t       r_desired_q, w_desired_d;
    // Direction under query, captured on entry to a query state so the
    // requested tile stays stable even if the joystick moves meanwhile.
    dir_t       r_qdir_q,    w_qdir_d;
    logic [9:0] r_x_q,       w_x_d;
    logic [9:0] r_y_q,       w_y_d;

    logic       w_aligned;
    logic       w_in_query;
    logic       w_oog;
    logic       w_resolved;

    pacman_next_tile #(
        .X_MAX      (X_MAX),
        .Y_MAX      (Y_MAX),
        .TILE_SHIFT (TILE_SHIFT)
    ) u_next_tile (
        .i_x           (r_x_q),
        .i_y           (r_y_q),
        .i_dir         (r_qdir_q),
        .o_row         (o_query_row),
        .o_col         (o_query_col),
        .o_out_of_grid (w_oog)
    );

    assign w_aligned  = (r_x_q[TILE_SHIFT-1:0] == '0) && (r_y_q[TILE_SHIFT-1:0] == '0);
    assign w_in_query = (r_state_q == S_TURN_Q) || (r_state_q == S_FWD_Q);
    // An off-grid neighbour is a wall known locally, so it resolves in the
    // same cycle without bothering the maze.
    assign w_resolved = w_oog || i_query_ack;

    always_comb begin
        w_state_d   = r_state_q;
        w_dir_d     = r_dir_q;
        w_desired_d = r_desired_q;
        w_qdir_d    = r_qdir_q;
        w_x_d       = r_x_q;
        w_y_d       = r_y_q;

        if (i_left)       w_desired_d = LEFT;
        else if (i_right) w_desired_d = RIGHT;
        else if (i_up)    w_desired_d = UP;
        else if (i_down)  w_desired_d = DOWN;

        case (r_state_q)
            S_IDLE: begin
                if (i_tick) begin
                    if ((r_desired_q != NONE) && (r_desired_q == f_opposite(r_dir_q))) begin
                        w_dir_d   = r_desired_q;
                        w_state_d = S_STEP;
                    end else if (w_aligned) begin
                        if ((r_desired_q != NONE) && (r_desired_q != r_dir_q)) begin
                            w_qdir_d  = r_desired_q;
                            w_state_d = S_TURN_Q;
                        end else if (r_dir_q != NONE) begin
                            w_qdir_d  = r_dir_q;
                            w_state_d = S_FWD_Q;
                        end
                    end else begin
                        w_state_d = S_STEP;
                    end
                end
            end
            S_TURN_Q: begin
                if (w_resolved) begin
                    if (!w_oog && !i_query_wall) begin
                        w_dir_d   = r_qdir_q;
                        w_state_d = S_STEP;
                    end else if (r_dir_q == NONE) begin
                        // Blocked turn from rest: nothing to continue in.
                        w_state_d = S_IDLE;
                    end else begin
                        w_qdir_d  = r_dir_q;
                        w_state_d = S_FWD_Q;
                    end
                end
            end
            S_FWD_Q: begin
                if (w_resolved) begin
                    if (!w_oog && !i_query_wall) begin
                        w_state_d = S_STEP;
                    end else begin
                        w_dir_d   = NONE;
                        w_state_d = S_IDLE;
                    end
                end
            end
            S_STEP: begin
                case (r_dir_q)
                    UP:      if (r_x_q != 10'd0)    w_x_d = r_x_q - 10'd1;
                    DOWN:    if (r_x_q <  c_XMAX_L) w_x_d = r_x_q + 10'd1;
                    LEFT:    if (r_y_q != 10'd0)    w_y_d = r_y_q - 10'd1;
                    RIGHT:   if (r_y_q <  c_YMAX_L) w_y_d = r_y_q + 10'd1;
                    default: ;
                endcase
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= S_IDLE;
            r_dir_q     <= NONE;
            r_desired_q <= NONE;
            r_qdir_q    <= NONE;
            r_x_q       <= c_START_X;
            r_y_q       <= c_START_Y;
        end else begin
            r_state_q   <= w_state_d;
            r_dir_q     <= w_dir_d;
            r_desired_q <= w_desired_d;
            r_qdir_q    <= w_qdir_d;
            r_x_q       <= w_x_d;
            r_y_q       <= w_y_d;
        end
    end

    assign o_query_req = w_in_query && !w_oog;
    assign o_busy      = (r_state_q != S_IDLE);
    assign o_dir       = r_dir_q;
    assign w_pacman_x  = r_x_q;
    assign w_pacman_y  = r_y_q;

endmodule : pacman_move_ctrl
`default_nettype wire

// File: tb/tb_pacman_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pacman_move_ctrl
//  Description : Directed self-checking bench for pacman_move_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pacman_move_ctrl;
    import pacman_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       tick = 1'b0;
    logic       ack = 1'b0, wall = 1'b0;
    logic       req;
    logic [6:0] row, col;
    logic [9:0] px, py;
    logic [2:0] dir;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    pacman_move_ctrl #(
        .X_MAX(272), .Y_MAX(208), .START_X(0), .START_Y(0), .TILE_SHIFT(3)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_up(up), .i_down(down), .i_left(left), .i_right(right),
        .i_tick(tick),
        .o_query_req(req), .o_query_row(row), .o_query_col(col),
        .i_query_ack(ack), .i_query_wall(wall),
        .w_pacman_x(px), .w_pacman_y(py),
        .o_dir(dir), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One movement tick, servicing any queries with the given wall answer.
    task automatic move_tick(input logic w);
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (req) begin ack = 1'b1; wall = w; end
            step_clk();
            ack = 1'b0; wall = 1'b0;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL move_tick_timeout: busy=%0b required 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; step_clk(); step_clk(); rst = 1'b0;
        n_checks++; if (px !== 10'd0)       begin n_fail++; $display("FAIL reset_x: got %0d required 0", px); end
        n_checks++; if (py !== 10'd0)       begin n_fail++; $display("FAIL reset_y: got %0d required 0", py); end
        n_checks++; if (dir !== 3'(NONE))   begin n_fail++; $display("FAIL reset_dir: got %0d required 0", dir); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_checks++; if (req !== 1'b0)       begin n_fail++; $display("FAIL reset_req: got %0b required 0", req); end
    endtask

    task automatic test_turn_from_rest();
        right = 1'b1; step_clk();
        tick = 1'b1; step_clk(); tick = 1'b0;
        n_checks++; if (req !== 1'b1)       begin n_fail++; $display("FAIL rest_req: got %0b required 1", req); end
        n_checks++; if (row !== 7'd0)       begin n_fail++; $display("FAIL rest_row: got %0d required 0", row); end
        n_checks++; if (col !== 7'd1)       begin n_fail++; $display("FAIL rest_col: got %0d required 1", col); end
        n_checks++; if (dir !== 3'(NONE))   begin n_fail++; $display("FAIL rest_dir_pre: got %0d required 0", dir); end
        step_clk(); step_clk();
        n_checks++; if (req !== 1'b1 || col !== 7'd1) begin n_fail++; $display("FAIL rest_req_hold: req=%0b col=%0d required 1/1", req, col); end
        ack = 1'b1; wall = 1'b0; step_clk(); ack = 1'b0;
        n_checks++; if (req !== 1'b0)       begin n_fail++; $display("FAIL rest_req_drop: got %0b required 0", req); end
        n_checks++; if (dir !== 3'(RIGHT))  begin n_fail++; $display("FAIL rest_dir: got %0d required %0d", dir, RIGHT); end
        n_checks++; if (py !== 10'd0)       begin n_fail++; $display("FAIL rest_y_early: got %0d required 0", py); end
        step_clk();
        n_checks++; if (py !== 10'd1)       begin n_fail++; $display("FAIL rest_y: got %0d required 1", py); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rest_busy: got %0b required 0", busy); end
        right = 1'b0;
    endtask

    task automatic test_reversal();
        for (int i = 0; i < 4; i++) move_tick(1'b0);
        n_checks++; if (py !== 10'd5)       begin n_fail++; $display("FAIL rev_y_start: got %0d required 5", py); end
        left = 1'b1; step_clk(); left = 1'b0;
        tick = 1'b1; step_clk(); tick = 1'b0;
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL rev_busy: got %0b required 1", busy); end
        n_checks++; if (dir !== 3'(LEFT))   begin n_fail++; $display("FAIL rev_dir: got %0d required %0d", dir, LEFT); end
        n_checks++; if (req !== 1'b0)       begin n_fail++; $display("FAIL rev_req: got %0b required 0", req); end
        n_checks++; if (py !== 10'd5)       begin n_fail++; $display("FAIL rev_y_n1: got %0d required 5", py); end
        step_clk();
        n_checks++; if (py !== 10'd4)       begin n_fail++; $display("FAIL rev_y_n2: got %0d required 4", py); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rev_busy_n2: got %0b required 0", busy); end
    endtask

    task automatic test_left_edge();
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) move_tick(1'b0);
        n_checks++; if (py !== 10'd0)       begin n_fail++; $display("FAIL edge_y_start: got %0d required 0", py); end
        tick = 1'b1; step_clk(); tick = 1'b0; saw = saw | req;
        step_clk(); saw = saw | req;
        n_checks++; if (saw !== 1'b0)       begin n_fail++; $display("FAIL edge_no_req: saw req=%0b required 0", saw); end
        n_checks++; if (dir !== 3'(NONE))   begin n_fail++; $display("FAIL edge_dir: got %0d required 0", dir); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL edge_busy: got %0b required 0", busy); end
    endtask

    // Walk to (8,16) heading RIGHT: down 8 pixels, then right 16.
    task automatic test_navigate();
        down = 1'b1; step_clk(); down = 1'b0;
        for (int i = 0; i < 8; i++) move_tick(1'b0);
        n_checks++; if (px !== 10'd8 || dir !== 3'(DOWN)) begin n_fail++; $display("FAIL nav_down: x=%0d dir=%0d required 8/%0d", px, dir, DOWN); end
        right = 1'b1; step_clk(); right = 1'b0;
        for (int i = 0; i < 16; i++) move_tick(1'b0);
        n_checks++; if (py !== 10'd16 || dir !== 3'(RIGHT)) begin n_fail++; $display("FAIL nav_right: y=%0d dir=%0d required 16/%0d", py, dir, RIGHT); end
    endtask

    task automatic test_turn_blocked();
        up = 1'b1; step_clk(); up = 1'b0;
        tick = 1'b1; step_clk(); tick = 1'b0;
        n_checks++; if (req !== 1'b1 || row !== 7'd0 || col !== 7'd2) begin n_fail++; $display("FAIL blk_turn_q: req=%0b row=%0d col=%0d required 1/0/2", req, row, col); end
        ack = 1'b1; wall = 1'b1; step_clk(); ack = 1'b0; wall = 1'b0;
        n_checks++; if (req !== 1'b1 || row !== 7'd1 || col !== 7'd3) begin n_fail++; $display("FAIL blk_fwd_q: req=%0b row=%0d col=%0d required 1/1/3", req, row, col); end
        n_checks++; if (dir !== 3'(RIGHT))  begin n_fail++; $display("FAIL blk_dir_mid: got %0d required %0d", dir, RIGHT); end
        ack = 1'b1; step_clk(); ack = 1'b0;
        n_checks++; if (req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL blk_step: req=%0b busy=%0b required 0/1", req, busy); end
        step_clk();
        n_checks++; if (py !== 10'd17 || px !== 10'd8) begin n_fail++; $display("FAIL blk_pos: x=%0d y=%0d required 8/17", px, py); end
        n_checks++; if (dir !== 3'(RIGHT))  begin n_fail++; $display("FAIL blk_dir: got %0d required %0d", dir, RIGHT); end
    endtask

    // Tick held high every cycle; queries answered after 5 cycles.
    task automatic test_back_to_back();
        int cycles, steps, acks, reqcnt;
        logic [9:0] prev_y;
        cycles = 0; steps = 0; acks = 0; reqcnt = 0;
        right = 1'b1; step_clk(); right = 1'b0;
        tick = 1'b1;
        for (int c = 0; c < 100 && py != 10'd26; c++) begin
            prev_y = py;
            if (req) begin
                reqcnt++;
                ack = (reqcnt == 5);
                if (reqcnt == 5) acks++;
            end else begin
                reqcnt = 0;
                ack = 1'b0;
            end
            step_clk();
            cycles++;
            if (py != prev_y) begin
                steps++;
                n_checks++; if (py !== prev_y + 10'd1) begin n_fail++; $display("FAIL b2b_delta: got %0d required %0d", py, prev_y + 10'd1); end
            end
        end
        tick = 1'b0; ack = 1'b0;
        n_checks++; if (py !== 10'd26)      begin n_fail++; $display("FAIL b2b_y: got %0d required 26", py); end
        n_checks++; if (steps != 9)         begin n_fail++; $display("FAIL b2b_steps: got %0d required 9", steps); end
        n_checks++; if (acks != 1)          begin n_fail++; $display("FAIL b2b_acks: got %0d required 1", acks); end
        n_checks++; if (cycles != 23)       begin n_fail++; $display("FAIL b2b_cycles: got %0d required 23", cycles); end
        n_checks++; if (px !== 10'd8)       begin n_fail++; $display("FAIL b2b_x: got %0d required 8", px); end
    endtask

    task automatic test_right_bound();
        logic saw;
        for (int i = 0; i < 400 && py < 10'd208; i++) move_tick(1'b0);
        n_checks++; if (py !== 10'd208 || dir !== 3'(RIGHT)) begin n_fail++; $display("FAIL bnd_reach: y=%0d dir=%0d required 208/%0d", py, dir, RIGHT); end
        saw = 1'b0;
        tick = 1'b1; step_clk(); tick = 1'b0; saw = saw | req;
        n_checks++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL bnd_fwd_busy: got %0b required 1", busy); end
        step_clk(); saw = saw | req;
        n_checks++; if (saw !== 1'b0)       begin n_fail++; $display("FAIL bnd_no_req: saw req=%0b required 0", saw); end
        n_checks++; if (dir !== 3'(NONE))   begin n_fail++; $display("FAIL bnd_dir: got %0d required 0", dir); end
        n_checks++; if (py !== 10'd208 || busy !== 1'b0) begin n_fail++; $display("FAIL bnd_pos: y=%0d busy=%0b required 208/0", py, busy); end
        saw = 1'b0;
        tick = 1'b1; step_clk(); tick = 1'b0; saw = saw | req;
        step_clk(); saw = saw | req;
        n_checks++; if (saw !== 1'b0 || busy !== 1'b0 || dir !== 3'(NONE) || py !== 10'd208) begin n_fail++; $display("FAIL bnd_retry: req=%0b busy=%0b dir=%0d y=%0d required 0/0/0/208", saw, busy, dir, py); end
    endtask

    task automatic test_reset_mid_query();
        up = 1'b1; step_clk();
        tick = 1'b1; step_clk(); tick = 1'b0;
        n_checks++; if (req !== 1'b1 || row !== 7'd0 || col !== 7'd26) begin n_fail++; $display("FAIL rq_query: req=%0b row=%0d col=%0d required 1/0/26", req, row, col); end
        rst = 1'b1; tick = 1'b1; step_clk();
        rst = 1'b0; tick = 1'b0; up = 1'b0;
        n_checks++; if (req !== 1'b0)       begin n_fail++; $display("FAIL rq_req: got %0b required 0", req); end
        n_checks++; if (px !== 10'd0 || py !== 10'd0) begin n_fail++; $display("FAIL rq_pos: x=%0d y=%0d required 0/0", px, py); end
        n_checks++; if (dir !== 3'(NONE) || busy !== 1'b0) begin n_fail++; $display("FAIL rq_state: dir=%0d busy=%0b required 0/0", dir, busy); end
        ack = 1'b1; wall = 1'b0; step_clk(); ack = 1'b0;
        n_checks++; if (busy !== 1'b0 || dir !== 3'(NONE) || py !== 10'd0) begin n_fail++; $display("FAIL rq_stale_ack: busy=%0b dir=%0d y=%0d required 0/0/0", busy, dir, py); end
        tick = 1'b1; step_clk(); tick = 1'b0;
        n_checks++; if (busy !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL rq_desired_cleared: busy=%0b req=%0b required 0/0", busy, req); end
    endtask

    initial begin
        step_clk();
        test_reset();
        test_turn_from_rest();
        test_reversal();
        test_left_edge();
        test_navigate();
        test_turn_blocked();
        test_back_to_back();
        test_right_bound();
        test_reset_mid_query();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pacman_move_ctrl
`default_nettype wire
